// File: rtl/dct_pkg.sv
// Shared types for the DCT datapath: 8-point block size and the signed sample word.
// The upstream row DCT, this transpose buffer and the column DCT all import it.
package dct_pkg;
  localparam int DCT_N  = 8;
  localparam int DATA_W = 32;

  typedef logic signed [DATA_W-1:0] dct_word_t;
  typedef dct_word_t dct_row_t [DCT_N];
endpackage

// File: rtl/tbuf_bank.sv
// One 8x8 bank of the transpose buffer: whole-row write port, whole-column read mux.
// Storage is deliberately not reset; the full flags in the parent decide validity.
module tbuf_bank
  import dct_pkg::*;
(
  input  logic     clk,
  input  logic     i_wr_en,
  input  logic [2:0] i_wr_row,
  input  dct_row_t i_wr_data,
  input  logic [2:0] i_rd_col,
  output dct_row_t o_rd_data
);

  dct_word_t r_mem [DCT_N][DCT_N];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int k = 0; k < DCT_N; k++) begin
        r_mem[i_wr_row][k] <= i_wr_data[k];
      end
    end
  end

  // Element k of the column comes from row k.
  always_comb begin
    for (int k = 0; k < DCT_N; k++) begin
      o_rd_data[k] = r_mem[k][i_rd_col];
    end
  end

endmodule

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows in from the row DCT, columns out to the column DCT.
// One bank fills while the other drains; a bank is free again the cycle after its column 7 leaves.
module dct_transpose_buf
  import dct_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int N      = 8
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in0,
  input  logic signed [DATA_W-1:0] in1,
  input  logic signed [DATA_W-1:0] in2,
  input  logic signed [DATA_W-1:0] in3,
  input  logic signed [DATA_W-1:0] in4,
  input  logic signed [DATA_W-1:0] in5,
  input  logic signed [DATA_W-1:0] in6,
  input  logic signed [DATA_W-1:0] in7,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out0,
  output logic signed [DATA_W-1:0] out1,
  output logic signed [DATA_W-1:0] out2,
  output logic signed [DATA_W-1:0] out3,
  output logic signed [DATA_W-1:0] out4,
  output logic signed [DATA_W-1:0] out5,
  output logic signed [DATA_W-1:0] out6,
  output logic signed [DATA_W-1:0] out7,
  output logic [2:0]               out_col,
  output logic                     out_last
);

  if (N != DCT_N) begin : g_bad_n
    $error("dct_transpose_buf: N must be 8");
  end
  if (DATA_W != dct_pkg::DATA_W) begin : g_bad_w
    $error("dct_transpose_buf: DATA_W must match dct_pkg::DATA_W");
  end

  localparam logic [2:0] LAST_IDX = 3'(DCT_N - 1);

  logic       r_wr_sel;
  logic [2:0] r_wr_row;
  logic       r_rd_sel;
  logic [2:0] r_rd_col;
  logic [1:0] r_full;

  logic       w_wr_acc;
  logic       w_rd_acc;
  logic [1:0] w_full_nxt;
  dct_row_t   w_in_row;
  dct_row_t   w_rd_bank0;
  dct_row_t   w_rd_bank1;
  dct_row_t   w_out_row;

  assign in_ready  = !r_full[r_wr_sel];
  assign out_valid = r_full[r_rd_sel];
  assign w_wr_acc  = in_valid && in_ready;
  assign w_rd_acc  = out_valid && out_ready;

  always_comb begin
    w_in_row[0] = in0;
    w_in_row[1] = in1;
    w_in_row[2] = in2;
    w_in_row[3] = in3;
    w_in_row[4] = in4;
    w_in_row[5] = in5;
    w_in_row[6] = in6;
    w_in_row[7] = in7;
  end

  tbuf_bank u_bank0 (
    .clk      (clk),
    .i_wr_en  (w_wr_acc && !r_wr_sel),
    .i_wr_row (r_wr_row),
    .i_wr_data(w_in_row),
    .i_rd_col (r_rd_col),
    .o_rd_data(w_rd_bank0)
  );

  tbuf_bank u_bank1 (
    .clk      (clk),
    .i_wr_en  (w_wr_acc && r_wr_sel),
    .i_wr_row (r_wr_row),
    .i_wr_data(w_in_row),
    .i_rd_col (r_rd_col),
    .o_rd_data(w_rd_bank1)
  );

  // Fill and release never target the same bank in one cycle: in_ready
  // for a bank stays low until its release edge has passed.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_acc && (r_wr_row == LAST_IDX)) w_full_nxt[r_wr_sel] = 1'b1;
    if (w_rd_acc && (r_rd_col == LAST_IDX)) w_full_nxt[r_rd_sel] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_sel <= 1'b0;
      r_wr_row <= 3'd0;
      r_rd_sel <= 1'b0;
      r_rd_col <= 3'd0;
      r_full   <= 2'b00;
    end else begin
      if (w_wr_acc) begin
        r_wr_row <= r_wr_row + 3'd1;
        if (r_wr_row == LAST_IDX) r_wr_sel <= ~r_wr_sel;
      end
      if (w_rd_acc) begin
        r_rd_col <= r_rd_col + 3'd1;
        if (r_rd_col == LAST_IDX) r_rd_sel <= ~r_rd_sel;
      end
      r_full <= w_full_nxt;
    end
  end

  // Everything presented downstream is zeroed while no column is valid.
  always_comb begin
    for (int k = 0; k < DCT_N; k++) begin
      w_out_row[k] = '0;
      if (out_valid) w_out_row[k] = r_rd_sel ? w_rd_bank1[k] : w_rd_bank0[k];
    end
  end

  assign out0     = w_out_row[0];
  assign out1     = w_out_row[1];
  assign out2     = w_out_row[2];
  assign out3     = w_out_row[3];
  assign out4     = w_out_row[4];
  assign out5     = w_out_row[5];
  assign out6     = w_out_row[6];
  assign out7     = w_out_row[7];
  assign out_col  = out_valid ? r_rd_col : 3'd0;
  assign out_last = out_valid && (r_rd_col == LAST_IDX);

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Scoreboard bench for dct_transpose_buf: the driver pushes expected columns when
// a block's eighth row is accepted; a negedge monitor pops and compares presented columns.
module tb_dct_transpose_buf;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic signed [31:0] in_r [8];
  logic out_valid;
  logic out_ready;
  logic signed [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [2:0] out_col;
  logic out_last;

  always #5 clk = ~clk;

  dct_transpose_buf #(.DATA_W(32), .N(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in0(in_r[0]), .in1(in_r[1]), .in2(in_r[2]), .in3(in_r[3]),
    .in4(in_r[4]), .in5(in_r[5]), .in6(in_r[6]), .in7(in_r[7]),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .out4(out4), .out5(out5), .out6(out6), .out7(out7),
    .out_col(out_col), .out_last(out_last)
  );

  typedef struct packed {
    logic [7:0][31:0] d;
    logic [2:0]       col;
    logic             last;
  } exp_t;

  exp_t        q[$];
  logic [31:0] blk [8][8];
  int          mrow = 0;
  int          rows_acc = 0;
  int          stalls = 0;
  int          checks = 0;
  int          errors = 0;
  logic        rnd_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp_v);
    end
  endtask

  // Reference model: collect the accepted row, emit the 8 transposed columns on row 7.
  task automatic model_accept(input logic [7:0][31:0] row);
    exp_t e;
    for (int k = 0; k < 8; k++) blk[mrow][k] = row[k];
    rows_acc++;
    mrow++;
    if (mrow == 8) begin
      for (int c = 0; c < 8; c++) begin
        for (int k = 0; k < 8; k++) e.d[k] = blk[k][c];
        e.col  = 3'(c);
        e.last = (c == 7);
        q.push_back(e);
      end
      mrow = 0;
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send_row(input logic [7:0][31:0] row, input int idle);
    int budget;
    repeat (idle) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) in_r[k] = row[k];
    budget = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(row);
        @(posedge clk); #1;
        in_valid = 1'b0;
        break;
      end
      stalls++;
      budget++;
      if (budget > 500) begin
        chk("row_accept_timeout", 32'(budget), 32'd0);
        in_valid = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic send_block(input logic [31:0] base, input int nrows);
    logic [7:0][31:0] row;
    for (int r = 0; r < nrows; r++) begin
      for (int k = 0; k < 8; k++) row[k] = base + 32'(r * 8 + k);
      send_row(row, 0);
    end
  endtask

  task automatic wait_drain();
    int b = 0;
    while (q.size() != 0 && b < 2000) begin @(posedge clk); b++; end
    #1;
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  // Monitor
  logic [7:0][31:0] w_obs;
  assign w_obs = {out7, out6, out5, out4, out3, out2, out1, out0};

  always @(negedge clk) begin
    exp_t obs;
    exp_t e;
    if (rst === 1'b0) begin
      obs.d = w_obs; obs.col = out_col; obs.last = out_last;
      checks++;
      if (out_valid === 1'b1) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL spurious_column actual col=%0d required no output", out_col);
        end else begin
          e = q[0];
          if (obs !== e) begin
            errors++;
            $display("FAIL column actual=%h/%0d/%0b required=%h/%0d/%0b",
                     obs.d, obs.col, obs.last, e.d, e.col, e.last);
          end
          if (out_ready) void'(q.pop_front());
        end
      end else if (obs !== '0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs actual=%h/%0d/%0b valid=%b required zero",
                 obs.d, obs.col, obs.last, out_valid);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog_timeout actual=expired required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0][31:0] row;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; rnd_done = 1'b0;
    for (int k = 0; k < 8; k++) in_r[k] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out0", out0, 32'd0);
    chk("reset_out_col", 32'(out_col), 32'd0);
    @(posedge clk); #1;

    // Single block with latency check
    out_ready = 1'b1;
    send_block(32'd0, 8);
    @(negedge clk);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("latency_out_col", 32'(out_col), 32'd0);
    chk("latency_out0", out0, 32'd0);
    wait_drain();
    @(posedge clk); #1;

    // Streaming: 4 blocks back to back, never stalled
    stalls = 0;
    for (int b = 0; b < 4; b++) send_block(32'(b * 64), 8);
    chk("stream_stalls", 32'(stalls), 32'd0);
    wait_drain();
    @(posedge clk); #1;

    // Backpressure: 3 blocks offered with out_ready low
    out_ready = 1'b0;
    rows_acc = 0;
    fork
      begin
        for (int b = 0; b < 3; b++) send_block(32'h1000_0000 + 32'(b * 64), 8);
      end
      begin
        repeat (40) @(posedge clk);
        @(negedge clk);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_rows_accepted", 32'(rows_acc), 32'd16);
        chk("bp_held_col", 32'(out_col), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          chk("bp_in_ready_during_drain", 32'(in_ready), 32'd0);
          @(posedge clk);
        end
        @(negedge clk);
        chk("bp_in_ready_after_col7", 32'(in_ready), 32'd1);
      end
    join
    wait_drain();
    @(posedge clk); #1;

    // Random handshake with extreme signed values
    fork
      begin
        for (int b = 0; b < 20; b++) begin
          for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 8; k++) begin
              row[k] = $urandom;
              if ((b + r + k) % 5 == 0) row[k] = 32'h7FFF_FFFF;
              else if ((b + r + k) % 7 == 0) row[k] = 32'h8000_0000;
            end
            send_row(row, int'($urandom_range(0, 1)));
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    @(posedge clk); #1;

    // Reset while one block drains at column 3 and another is 5 rows in
    out_ready = 1'b0;
    send_block(32'hA000_0000, 8);
    send_block(32'hB000_0000, 5);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("pre_reset_col", 32'(out_col), 32'd3);
    @(posedge clk); #1;
    rst = 1'b1;
    q.delete();
    mrow = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    chk("post_reset_out7", out7, 32'd0);
    chk("post_reset_last", 32'(out_last), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_block(32'hC000_0000, 8);
    wait_drain();
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
